render_sequencer: RTL and testbench
===================================

RENDER_SEQUENCER -- requirements
Module: render_sequencer

Interface
REQ-001 SHALL have parameter FRAME_DIV, default 833333, meaning clk cycles per frame tick (50 MHz / 60 Hz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 131072, meaning max cycles a client may take before done.
REQ-003 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  in  1  game running; frame ticks are acted on only while high.
REQ-006 SHALL have ports bg_done, bg_we (in 1), bg_x (in 9), bg_y (in 8), bg_colour (in 3): the background drawer's done, write strobe and pixel.
REQ-007 SHALL have ports sp_done, sp_we (in 1), sp_x (in 9), sp_y (in 8), sp_colour (in 3): the sprite drawer's equivalents.
REQ-008 SHALL have ports bg_plot, sp_plot  out  1  one-cycle start pulse to each drawer.
REQ-009 SHALL have port frame  out  1  one-cycle pulse marking a completed frame; steps scroll offset and game logic.
REQ-010 SHALL have ports vga_x (out 9), vga_y (out 8), vga_colour (out 3), vga_we (out 1): pixel write to the VGA adapter.
REQ-011 SHALL have ports busy, overrun, timeout  out  1  status flags.

Function
REQ-012 Tick counter SHALL count 0..FRAME_DIV-1 and wrap; the internal tick is high in the cycle the count equals FRAME_DIV-1.
REQ-013 FSM states SHALL be S_IDLE, S_BG_START, S_BG_WAIT, S_SP_START, S_SP_WAIT, S_FRAME_DONE.
REQ-014 S_IDLE -> S_BG_START on tick with enable=1; otherwise remain.
REQ-015 S_BG_START SHALL assert bg_plot for exactly one cycle, then go to S_BG_WAIT.
REQ-016 S_BG_WAIT -> S_SP_START on bg_done=1; bg_done SHALL be ignored in every other state.
REQ-017 S_SP_START SHALL assert sp_plot for one cycle, then go to S_SP_WAIT; S_SP_WAIT -> S_FRAME_DONE on sp_done=1.
REQ-018 S_FRAME_DONE SHALL assert frame for one cycle, then go to S_IDLE.
REQ-019 busy SHALL be 1 in every state except S_IDLE.
REQ-020 A tick arriving while not in S_IDLE SHALL be dropped and SHALL set overrun, which stays set until reset.
REQ-021 vga_* SHALL be registered, one cycle of latency: in S_BG_START/S_BG_WAIT they copy bg_*; in S_SP_START/S_SP_WAIT they copy sp_*; in other states vga_we=0 and x/y/colour hold.
REQ-022 A client write strobe outside its own phase SHALL never reach vga_we.
REQ-023 bg_plot, sp_plot and frame SHALL never be high in the same cycle.

Reset
REQ-024 While reset=1, the block SHALL on each clock set: state S_IDLE, tick counter 0, all outputs 0, and overrun and timeout cleared.
REQ-025 Reset mid-frame SHALL abort the sequence with no frame pulse; the next accepted tick SHALL restart from S_BG_START.

Configuration
REQ-026 With RENDER_SEQ_TIMEOUT_EN defined, a wait counter SHALL clear on entry to S_BG_WAIT or S_SP_WAIT.
REQ-027 If that counter reaches TIMEOUT_CYCLES without the matching done, the FSM SHALL advance as if done had arrived, and timeout SHALL set sticky.
REQ-028 Without RENDER_SEQ_TIMEOUT_EN, the wait states SHALL wait indefinitely, and the timeout port SHALL exist, tied to 0.

Verification (FRAME_DIV=100, TIMEOUT_CYCLES=50)
REQ-029 Normal frame:
- stimulus: enable=1; bg_done 20 cycles after bg_plot; sp_done 10 cycles after sp_plot.
- response: bg_plot at cycle 100; sp_plot, then frame once; busy 0 afterwards; overrun=0.
REQ-030 Pass-through:
- stimulus: bg_we=1, bg_x=5, bg_y=7, bg_colour=3'b101 in S_BG_WAIT.
- response: vga_we=1, vga_x=5, vga_y=7, vga_colour=3'b101 one cycle later.
- also: sp_we=1 in the same cycle produces no VGA write.
REQ-031 Overrun: hold bg_done=0 for 150 cycles -> the second tick is dropped; overrun=1 and remains 1 until reset.
REQ-032 Reset mid-operation: reset=1 for one cycle during S_SP_WAIT -> all outputs 0, no frame pulse, and the next tick yields bg_plot.
REQ-033 Timeout:
- with macro: bg_done never asserted -> sp_plot 50 cycles after entering S_BG_WAIT, timeout=1.
- without macro: FSM stays in S_BG_WAIT, timeout=0.
REQ-034 Disabled: enable=0 across 3 ticks -> no plot pulses, busy=0, overrun=0.

Source files
------------

// File: rtl/render_sequencer.sv
// Frame-tick driven render sequencer: each accepted tick runs the background drawer, then the
// sprite drawer, forwarding the active drawer's pixel writes to the VGA port.
// Optional build macro RENDER_SEQ_TIMEOUT_EN bounds each drawer wait to TIMEOUT_CYCLES.
//
// Handshake: bg_plot/sp_plot are single-cycle start pulses; a drawer answers with bg_done/sp_done,
// which is sampled only while the sequencer is waiting on that drawer and ignored everywhere else.
module render_sequencer #(
    parameter int FRAME_DIV      = 833333,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       bg_done,
    input  logic       bg_we,
    input  logic [8:0] bg_x,
    input  logic [7:0] bg_y,
    input  logic [2:0] bg_colour,
    input  logic       sp_done,
    input  logic       sp_we,
    input  logic [8:0] sp_x,
    input  logic [7:0] sp_y,
    input  logic [2:0] sp_colour,
    output logic       bg_plot,
    output logic       sp_plot,
    output logic       frame,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_we,
    output logic       busy,
    output logic       overrun,
    output logic       timeout,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BG_START   = 3'd1,
        S_BG_WAIT    = 3'd2,
        S_SP_START   = 3'd3,
        S_SP_WAIT    = 3'd4,
        S_FRAME_DONE = 3'd5
    } state_t;

`ifdef RENDER_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   tick_cnt;
    logic            tick;
    logic [WW-1:0]   wait_cnt;
    logic            wait_expired;
    logic            timeout_q;

    assign tick = (tick_cnt == CW'(FRAME_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    // The wait counter is zeroed in each START state, so it reads 0 on the first wait cycle.
    always_ff @(posedge clk) begin
        if (reset || state == S_BG_START || state == S_SP_START) begin
            wait_cnt <= '0;
        end else if (state == S_BG_WAIT || state == S_SP_WAIT) begin
            wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign wait_expired = TIMEOUT_EN && (wait_cnt == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bg_plot    = 1'b0;
        sp_plot    = 1'b0;
        frame      = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (tick && enable) state_next = S_BG_START;
            end
            S_BG_START: begin
                bg_plot    = 1'b1;
                state_next = S_BG_WAIT;
            end
            S_BG_WAIT: begin
                if (bg_done || wait_expired) state_next = S_SP_START;
            end
            S_SP_START: begin
                sp_plot    = 1'b1;
                state_next = S_SP_WAIT;
            end
            S_SP_WAIT: begin
                if (sp_done || wait_expired) state_next = S_FRAME_DONE;
            end
            S_FRAME_DONE: begin
                frame      = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Sticky status; a tick is only dropped (and flagged) when the game is running.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (tick && enable && state != S_IDLE) overrun <= 1'b1;
            if (wait_expired && ((state == S_BG_WAIT && !bg_done) ||
                                 (state == S_SP_WAIT && !sp_done))) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout   = TIMEOUT_EN ? timeout_q : 1'b0;
    assign state_dbg = state;

    // VGA bus follows the drawer owning the current phase; stray strobes are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_we     <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            case (state)
                S_BG_START, S_BG_WAIT: begin
                    vga_we     <= bg_we;
                    vga_x      <= bg_x;
                    vga_y      <= bg_y;
                    vga_colour <= bg_colour;
                end
                S_SP_START, S_SP_WAIT: begin
                    vga_we     <= sp_we;
                    vga_x      <= sp_x;
                    vga_y      <= sp_y;
                    vga_colour <= sp_colour;
                end
                default: vga_we <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer (FRAME_DIV=100, TIMEOUT_CYCLES=50): a phase-level model
// compared every cycle, plus directed scenarios with hand-computed cycle numbers.
module tb_render_sequencer;

    localparam int FD = 100;
    localparam int TC = 50;
`ifdef RENDER_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       enable;
    logic       bg_done, bg_we, sp_done, sp_we;
    logic [8:0] bg_x, sp_x, vga_x;
    logic [7:0] bg_y, sp_y, vga_y;
    logic [2:0] bg_colour, sp_colour, vga_colour, state_dbg;
    logic       bg_plot, sp_plot, frame, vga_we, busy, overrun, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    render_sequencer #(.FRAME_DIV(FD), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .bg_done(bg_done), .bg_we(bg_we), .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour),
        .sp_done(sp_done), .sp_we(sp_we), .sp_x(sp_x), .sp_y(sp_y), .sp_colour(sp_colour),
        .bg_plot(bg_plot), .sp_plot(sp_plot), .frame(frame),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_we(vga_we),
        .busy(busy), .overrun(overrun), .timeout(timeout), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: who owns the bus and which pulse is due ----------------
    // owner: 0 none, 1 background, 2 sprite; pulse: 0 none, 1 bg_plot, 2 sp_plot, 3 frame
    int         cyc, owner, pulse, waited;
    int         n_owner, n_pulse, n_waited;
    bit         m_valid = 1'b0;
    bit         m_ov, m_to, tick_m, busy_m;
    logic       m_we;
    logic [8:0] m_x;
    logic [7:0] m_y;
    logic [2:0] m_c;

    always @(negedge clk) begin
        if (m_valid) begin
            busy_m = (owner != 0) || (pulse == 3);
            check("bg_plot",    bg_plot,    pulse == 1);
            check("sp_plot",    sp_plot,    pulse == 2);
            check("frame",      frame,      pulse == 3);
            check("busy",       busy,       busy_m);
            check("overrun",    overrun,    m_ov);
            check("timeout",    timeout,    m_to);
            check("vga_we",     vga_we,     m_we);
            check("vga_x",      vga_x,      m_x);
            check("vga_y",      vga_y,      m_y);
            check("vga_colour", vga_colour, m_c);
        end
        if (reset) begin
            cyc = 0; owner = 0; pulse = 0; waited = 0;
            m_ov = 1'b0; m_to = 1'b0;
            m_we = 1'b0; m_x = '0; m_y = '0; m_c = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            tick_m = (cyc % FD) == FD - 1;
            busy_m = (owner != 0) || (pulse == 3);
            if (owner == 1) begin
                m_we = bg_we; m_x = bg_x; m_y = bg_y; m_c = bg_colour;
            end else if (owner == 2) begin
                m_we = sp_we; m_x = sp_x; m_y = sp_y; m_c = sp_colour;
            end else begin
                m_we = 1'b0;
            end
            n_owner  = owner;
            n_pulse  = 0;
            n_waited = waited + 1;
            if (pulse == 1 || pulse == 2) begin
                n_waited = 0;
            end else if (pulse == 0 && owner == 1) begin
                if (bg_done) begin
                    n_owner = 2; n_pulse = 2;
                end else if (TO_EN && waited == TC - 1) begin
                    n_owner = 2; n_pulse = 2; m_to = 1'b1;
                end
            end else if (pulse == 0 && owner == 2) begin
                if (sp_done) begin
                    n_owner = 0; n_pulse = 3;
                end else if (TO_EN && waited == TC - 1) begin
                    n_owner = 0; n_pulse = 3; m_to = 1'b1;
                end
            end
            if (tick_m && enable) begin
                if (busy_m) m_ov = 1'b1;
                else begin
                    n_owner = 1; n_pulse = 1;
                end
            end
            owner  = n_owner;
            pulse  = n_pulse;
            waited = n_waited;
            cyc    = cyc + 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bg_plot;
            1:       return sp_plot;
            default: return frame;
        endcase
    endfunction

    task automatic wait_for(input string name, input int which, input int limit, output int n);
        n = 0;
        while (sel(which) !== 1'b1 && n < limit) begin
            step(1);
            n++;
        end
        if (n >= limit) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no pulse within %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    int n;
    int pulses;

    initial begin
        reset = 1'b1; enable = 1'b1;
        bg_done = 1'b0; bg_we = 1'b0; bg_x = '0; bg_y = '0; bg_colour = '0;
        sp_done = 1'b0; sp_we = 1'b0; sp_x = '0; sp_y = '0; sp_colour = '0;
        step(2);
        reset = 1'b0;
        check("reset_busy", busy, 1'b0);
        check("reset_vga_we", vga_we, 1'b0);

        // normal frame with pass-through; cycle 0 is the first cycle out of reset
        wait_for("first_bg_plot", 0, 300, n);
        check("bg_plot_cycle", n, 100);
        step(5);
        bg_we = 1'b1; bg_x = 9'd5; bg_y = 8'd7; bg_colour = 3'b101;
        sp_we = 1'b1; sp_x = 9'd300; sp_y = 8'd200; sp_colour = 3'b010;
        step(1);
        check("pass_vga_we", vga_we, 1'b1);
        check("pass_vga_x", vga_x, 9'd5);
        check("pass_vga_y", vga_y, 8'd7);
        check("pass_vga_colour", vga_colour, 3'b101);
        bg_we = 1'b0;
        step(1);
        check("stray_sp_we", vga_we, 1'b0);
        sp_we = 1'b0;
        step(13);
        bg_done = 1'b1;
        step(1);
        bg_done = 1'b0;
        wait_for("sp_plot", 1, 100, n);
        check("sp_plot_delay", n, 0);
        step(10);
        sp_done = 1'b1;
        step(1);
        sp_done = 1'b0;
        wait_for("frame", 2, 100, n);
        check("frame_delay", n, 0);
        step(1);
        check("idle_after_frame", busy, 1'b0);
        check("no_overrun", overrun, 1'b0);

        // overrun: background drawer stalls across the next tick
        wait_for("bg_plot_2", 0, 200, n);
        check("bg_plot_2_cycle", n, 67);
        step(150);
        check("overrun_set", overrun, 1'b1);
        step(20);
        check("overrun_sticky", overrun, 1'b1);
        do_reset();
        check("overrun_cleared", overrun, 1'b0);

        // reset in the sprite wait aborts the frame
        wait_for("bg_plot_3", 0, 300, n);
        check("bg_plot_3_cycle", n, 100);
        step(5);
        bg_done = 1'b1;
        step(1);
        bg_done = 1'b0;
        step(3);
        sp_we = 1'b1; sp_x = 9'd300; sp_y = 8'd200; sp_colour = 3'b110;
        step(1);
        sp_we = 1'b0;
        step(1);
        check("sp_write_seen", vga_x, 9'd300);
        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_vga_x", vga_x, 9'd0);
        check("rst_vga_colour", vga_colour, 3'd0);
        wait_for("bg_plot_after_rst", 0, 300, n);
        check("bg_plot_after_rst_cycle", n, 100);

        // timeout: background drawer never finishes
        if (TO_EN) begin
            wait_for("sp_plot_timeout", 1, 80, n);
            check("timeout_sp_plot_delay", n, 51);
            step(1);
            check("timeout_flag", timeout, 1'b1);
        end else begin
            step(80);
            check("stuck_busy", busy, 1'b1);
            check("stuck_timeout", timeout, 1'b0);
        end
        do_reset();

        // disabled: three ticks pass with nothing started
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 350; i++) begin
            if (bg_plot || sp_plot || frame) pulses++;
            step(1);
        end
        check("disabled_pulses", pulses, 0);
        check("disabled_busy", busy, 1'b0);
        check("disabled_overrun", overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
